// File: rtl/interleaver_pingpong_ctrl_if.sv
// Handshake bundle for the interleaver ping-pong controller.
// INTLV_EARLY_END_EN adds the blk_end write-side input.
interface interleaver_pingpong_ctrl_if #(
    parameter int ADDR_W = 13
);
    logic              start_ready;
    logic              blk_start;
    logic              blk_sel;
    logic              in_valid;
    logic              in_ready;
`ifdef INTLV_EARLY_END_EN
    logic              blk_end;
`endif
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              out_valid;
    logic              out_ready;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_blk_sel;
    logic              out_last;
    logic              blk_done;

    modport master (
        input  blk_start, blk_sel, in_valid, out_ready,
`ifdef INTLV_EARLY_END_EN
        input  blk_end,
`endif
        output start_ready, in_ready, wr_en, wr_bank, wr_addr,
               out_valid, rd_bank, rd_idx, rd_blk_sel, out_last, blk_done
    );

    modport slave (
        output blk_start, blk_sel, in_valid, out_ready,
`ifdef INTLV_EARLY_END_EN
        output blk_end,
`endif
        input  start_ready, in_ready, wr_en, wr_bank, wr_addr,
               out_valid, rd_bank, rd_idx, rd_blk_sel, out_last, blk_done
    );
endinterface

// File: rtl/interleaver_pingpong_ctrl.sv
// Ping-pong bank sequencer for the block interleaver: one bank fills while the other drains.
// Define INTLV_EARLY_END_EN to allow blk_end to terminate a block short of K.
module interleaver_pingpong_ctrl #(
    parameter int ADDR_W = 13,
    parameter int K0     = 1056,
    parameter int K1     = 6144
) (
    input  logic                       clk,
    input  logic                       reset,
    interleaver_pingpong_ctrl_if.master bus
);
    typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_DRAIN} bank_st_e;
    typedef enum logic {W_IDLE, W_FILL} w_st_e;
    typedef enum logic {R_IDLE, R_DRAIN} r_st_e;

    localparam logic [ADDR_W-1:0] K0_M1 = ADDR_W'(K0 - 1);
    localparam logic [ADDR_W-1:0] K1_M1 = ADDR_W'(K1 - 1);

    w_st_e             w_st_q, w_st_d;
    r_st_e             r_st_q, r_st_d;
    bank_st_e          bank_st_q [2];
    bank_st_e          bank_st_d [2];
    logic [ADDR_W-1:0] len_m1_q [2];
    logic [ADDR_W-1:0] len_m1_d [2];
    logic              sel_q [2];
    logic              sel_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic              blk_done_q, blk_done_d;

    logic start_ready, in_ready, wr_en, wr_last, out_valid, out_last;

    assign start_ready = (w_st_q == W_IDLE) && (bank_st_q[wr_bank_q] == B_EMPTY);
    assign in_ready    = (w_st_q == W_FILL);
    assign wr_en       = bus.in_valid & in_ready;
    assign out_valid   = (r_st_q == R_DRAIN);
    assign out_last    = out_valid && (rd_idx_q == len_m1_q[rd_bank_q]);
`ifdef INTLV_EARLY_END_EN
    assign wr_last     = (wr_addr_q == len_m1_q[wr_bank_q]) || bus.blk_end;
`else
    assign wr_last     = (wr_addr_q == len_m1_q[wr_bank_q]);
`endif

    // Write and read sides only ever touch banks in disjoint states, so both may update in one cycle.
    always_comb begin
        w_st_d     = w_st_q;
        r_st_d     = r_st_q;
        bank_st_d  = bank_st_q;
        len_m1_d   = len_m1_q;
        sel_d      = sel_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_addr_d  = wr_addr_q;
        rd_idx_d   = rd_idx_q;
        blk_done_d = 1'b0;

        case (w_st_q)
            W_IDLE: begin
                if (bus.blk_start && start_ready) begin
                    bank_st_d[wr_bank_q] = B_FILL;
                    len_m1_d[wr_bank_q]  = bus.blk_sel ? K1_M1 : K0_M1;
                    sel_d[wr_bank_q]     = bus.blk_sel;
                    wr_addr_d            = '0;
                    w_st_d               = W_FILL;
                end
            end
            default: begin
                if (wr_en) begin
                    if (wr_last) begin
                        // On a normal last write wr_addr already equals len_m1.
                        bank_st_d[wr_bank_q] = B_FULL;
                        len_m1_d[wr_bank_q]  = wr_addr_q;
                        wr_bank_d            = ~wr_bank_q;
                        wr_addr_d            = '0;
                        w_st_d               = W_IDLE;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
            end
        endcase

        case (r_st_q)
            R_IDLE: begin
                if (bank_st_q[rd_bank_q] == B_FULL) begin
                    bank_st_d[rd_bank_q] = B_DRAIN;
                    rd_idx_d             = '0;
                    r_st_d               = R_DRAIN;
                end
            end
            default: begin
                if (bus.out_ready) begin
                    if (out_last) begin
                        bank_st_d[rd_bank_q] = B_EMPTY;
                        rd_bank_d            = ~rd_bank_q;
                        rd_idx_d             = '0;
                        r_st_d               = R_IDLE;
                        blk_done_d           = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q + ADDR_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_st_q     <= W_IDLE;
            r_st_q     <= R_IDLE;
            bank_st_q  <= '{B_EMPTY, B_EMPTY};
            len_m1_q   <= '{'0, '0};
            sel_q      <= '{1'b0, 1'b0};
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            rd_idx_q   <= '0;
            blk_done_q <= 1'b0;
        end else begin
            w_st_q     <= w_st_d;
            r_st_q     <= r_st_d;
            bank_st_q  <= bank_st_d;
            len_m1_q   <= len_m1_d;
            sel_q      <= sel_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_addr_q  <= wr_addr_d;
            rd_idx_q   <= rd_idx_d;
            blk_done_q <= blk_done_d;
        end
    end

    assign bus.start_ready = start_ready;
    assign bus.in_ready    = in_ready;
    assign bus.wr_en       = wr_en;
    assign bus.wr_bank     = wr_bank_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.out_valid   = out_valid;
    assign bus.rd_bank     = rd_bank_q;
    assign bus.rd_idx      = rd_idx_q;
    assign bus.rd_blk_sel  = out_valid & sel_q[rd_bank_q];
    assign bus.out_last    = out_last;
    assign bus.blk_done    = blk_done_q;
endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// Self-checking bench: block-level reference model checked every cycle, plus directed literal checks.
module tb_interleaver_pingpong_ctrl;
    localparam int ADDR_W = 4;
    localparam int K0 = 8;
    localparam int K1 = 12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    interleaver_pingpong_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    interleaver_pingpong_ctrl #(.ADDR_W(ADDR_W), .K0(K0), .K1(K1)) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int nchecks = 0;
    int nfail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: blocks as records; a completed block waits in a queue until the reader takes it.
    typedef struct {int bank; int len; int sel;} blk_t;
    int   m_wr_active = 0, m_wbank = 0, m_wcnt = 0, m_wlen = 0, m_wsel = 0;
    int   m_occ [2] = '{0, 0};
    blk_t m_fullq[$];
    blk_t m_rblk;
    int   m_rd_active = 0, m_rbank = 0, m_rcnt = 0, m_done = 0;

    task automatic m_reset();
        m_wr_active = 0; m_wbank = 0; m_wcnt = 0; m_wlen = 0; m_wsel = 0;
        m_occ[0] = 0; m_occ[1] = 0;
        m_fullq.delete();
        m_rd_active = 0; m_rbank = 0; m_rcnt = 0; m_done = 0;
        m_rblk.bank = 0; m_rblk.len = 1; m_rblk.sel = 0;
    endtask

    task automatic m_step();
        int   start_ok, done_n, wend;
        blk_t b;
        start_ok = (m_wr_active == 0) && (m_occ[m_wbank] == 0);
        done_n = 0;
        if (m_rd_active != 0) begin
            if (bus.out_ready) begin
                if (m_rcnt == m_rblk.len - 1) begin
                    m_occ[m_rbank] = 0;
                    m_rbank = 1 - m_rbank;
                    m_rcnt = 0;
                    m_rd_active = 0;
                    done_n = 1;
                end else m_rcnt++;
            end
        end else if (m_fullq.size() > 0) begin
            m_rblk = m_fullq.pop_front();
            m_rd_active = 1;
            m_rcnt = 0;
        end
        if (m_wr_active == 0) begin
            if (bus.blk_start && start_ok != 0) begin
                m_wr_active = 1;
                m_occ[m_wbank] = 1;
                m_wcnt = 0;
                m_wsel = int'(bus.blk_sel);
                m_wlen = bus.blk_sel ? K1 : K0;
            end
        end else if (bus.in_valid) begin
            wend = (m_wcnt == m_wlen - 1);
`ifdef INTLV_EARLY_END_EN
            if (bus.blk_end) wend = 1;
`endif
            if (wend != 0) begin
                b.bank = m_wbank; b.len = m_wcnt + 1; b.sel = m_wsel;
                m_fullq.push_back(b);
                m_wbank = 1 - m_wbank;
                m_wcnt = 0;
                m_wr_active = 0;
            end else m_wcnt++;
        end
        m_done = done_n;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) m_reset();
        else m_step();
    end

    // Monitor logs for directed checks
    int mon_wr_addr[$], mon_wr_bank[$], mon_rd_idx[$], mon_last_idx[$], mon_sel[$];
    int mon_done = 0, cyc = 0, last_wr_cyc = -1, first_ov_cyc = -1, overlap = 0;

    task automatic clear_mon();
        mon_wr_addr.delete(); mon_wr_bank.delete(); mon_rd_idx.delete();
        mon_last_idx.delete(); mon_sel.delete();
        mon_done = 0; last_wr_cyc = -1; first_ov_cyc = -1; overlap = 0;
    endtask

    always @(negedge clk) begin
        chk("start_ready", int'(bus.start_ready), int'(m_wr_active == 0 && m_occ[m_wbank] == 0));
        chk("in_ready",    int'(bus.in_ready),    m_wr_active);
        chk("wr_en",       int'(bus.wr_en),       int'(m_wr_active != 0 && bus.in_valid));
        chk("wr_bank",     int'(bus.wr_bank),     m_wbank);
        chk("wr_addr",     int'(bus.wr_addr),     m_wcnt);
        chk("out_valid",   int'(bus.out_valid),   m_rd_active);
        chk("rd_bank",     int'(bus.rd_bank),     m_rbank);
        chk("rd_idx",      int'(bus.rd_idx),      m_rcnt);
        chk("rd_blk_sel",  int'(bus.rd_blk_sel),  (m_rd_active != 0) ? m_rblk.sel : 0);
        chk("out_last",    int'(bus.out_last),    int'(m_rd_active != 0 && m_rcnt == m_rblk.len - 1));
        chk("blk_done",    int'(bus.blk_done),    m_done);
        cyc++;
        if (bus.wr_en) begin
            mon_wr_addr.push_back(int'(bus.wr_addr));
            mon_wr_bank.push_back(int'(bus.wr_bank));
            last_wr_cyc = cyc;
            if (bus.wr_bank && bus.out_valid && !bus.rd_bank) overlap = 1;
        end
        if (bus.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (bus.out_valid && bus.out_ready) begin
            mon_rd_idx.push_back(int'(bus.rd_idx));
            if (bus.out_last) begin
                mon_last_idx.push_back(int'(bus.rd_idx));
                mon_sel.push_back(int'(bus.rd_blk_sel));
            end
        end
        if (bus.blk_done) mon_done++;
    end

    // Index of first deviation from the runs 0..a-1 then 0..b-1, or -1 when the log matches.
    function automatic int seq_err(input int q[$], input int a, input int b);
        int k = 0;
        for (int i = 0; i < a; i++) begin
            if (k >= q.size() || q[k] != i) return k;
            k++;
        end
        for (int i = 0; i < b; i++) begin
            if (k >= q.size() || q[k] != i) return k;
            k++;
        end
        if (k != q.size()) return k;
        return -1;
    endfunction

    function automatic int bank_err(input int q[$], input int a, input int b);
        if (q.size() != a + b) return q.size();
        for (int i = 0; i < a + b; i++)
            if (q[i] != ((i < a) ? 0 : 1)) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.blk_start = 1'b0; bus.in_valid = 1'b0;
`ifdef INTLV_EARLY_END_EN
        bus.blk_end = 1'b0;
`endif
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic start_blk(input logic sel);
        int n = 0;
        while (!bus.start_ready && n < 200) begin tick(); n++; end
        chk("start_wait", int'(bus.start_ready), 1);
        bus.blk_start = 1'b1; bus.blk_sel = sel;
        tick();
        bus.blk_start = 1'b0;
    endtask

    // mode 0: continuous in_valid, mode 1: toggling; end_at>0 raises blk_end on that write.
    task automatic write_data(input int mode, input int end_at);
        int   nw = 0, done = 0;
        logic wr;
        for (int n = 0; n < 400 && done == 0; n++) begin
            bus.in_valid = (mode == 0) ? 1'b1 : ((n % 2) == 0);
`ifdef INTLV_EARLY_END_EN
            bus.blk_end = bus.in_valid && (nw == end_at - 1);
`endif
            @(negedge clk);
            wr = bus.wr_en;
            tick();
            if (wr) nw++;
            if (wr && !bus.in_ready) done = 1;
        end
        bus.in_valid = 1'b0;
`ifdef INTLV_EARLY_END_EN
        bus.blk_end = 1'b0;
`endif
        chk("write_finish", done, 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (mon_done < target && n < budget) begin tick(); n++; end
        chk("done_timeout", mon_done, target);
    endtask

    int exp_len;

    initial begin
        bus.blk_start = 1'b0; bus.blk_sel = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
`ifdef INTLV_EARLY_END_EN
        bus.blk_end = 1'b0;
`endif
        #1;
        // T1 reset
        reset = 1'b1;
        tick();
        chk("t1_start_ready", int'(bus.start_ready), 1);
        chk("t1_in_ready",    int'(bus.in_ready), 0);
        chk("t1_out_valid",   int'(bus.out_valid), 0);
        chk("t1_blk_done",    int'(bus.blk_done), 0);
        reset = 1'b0;
        tick();

        // T2 single block
        bus.out_ready = 1'b1;
        clear_mon();
        start_blk(1'b0);
        write_data(0, -1);
        wait_done(1, 60);
        chk("t2_wr_seq",  seq_err(mon_wr_addr, 8, 0), -1);
        chk("t2_wr_bank", bank_err(mon_wr_bank, 8, 0), -1);
        chk("t2_rd_seq",  seq_err(mon_rd_idx, 8, 0), -1);
        chk("t2_last",    (mon_last_idx.size() == 1) ? mon_last_idx[0] : -1, 7);
        chk("t2_latency", first_ov_cyc - last_wr_cyc, 2);
        tick(); tick();
        chk("t2_done_cnt", mon_done, 1);

        // T3 ping-pong
        do_reset();
        bus.out_ready = 1'b1;
        clear_mon();
        start_blk(1'b1);
        write_data(0, -1);
        start_blk(1'b0);
        write_data(0, -1);
        wait_done(2, 100);
        chk("t3_wr_seq",  seq_err(mon_wr_addr, 12, 8), -1);
        chk("t3_wr_bank", bank_err(mon_wr_bank, 12, 8), -1);
        chk("t3_rd_seq",  seq_err(mon_rd_idx, 12, 8), -1);
        chk("t3_sel",     (mon_sel.size() == 2) ? mon_sel[0] * 2 + mon_sel[1] : -1, 2);
        chk("t3_overlap", overlap, 1);

        // T4 backpressure and gaps
        do_reset();
        bus.out_ready = 1'b0;
        clear_mon();
        start_blk(1'b0);
        write_data(1, -1);
        start_blk(1'b0);
        write_data(1, -1);
        tick();
        chk("t4_start_ready", int'(bus.start_ready), 0);
        bus.blk_start = 1'b1; bus.blk_sel = 1'b1;
        tick();
        bus.blk_start = 1'b0;
        tick(); tick();
        chk("t4_ignored_start", int'(bus.in_ready), 0);
        chk("t4_hold_valid", int'(bus.out_valid), 1);
        chk("t4_hold_idx",   int'(bus.rd_idx), 0);
        bus.out_ready = 1'b1;
        wait_done(2, 100);
        tick(); tick(); tick();
        chk("t4_wr_seq", seq_err(mon_wr_addr, 8, 8), -1);
        chk("t4_rd_seq", seq_err(mon_rd_idx, 8, 8), -1);
        chk("t4_no_third", int'(bus.out_valid), 0);

        // T5 reset mid-fill
        do_reset();
        bus.out_ready = 1'b1;
        start_blk(1'b0);
        bus.in_valid = 1'b1;
        repeat (5) tick();
        chk("t5_addr5", int'(bus.wr_addr), 5);
        reset = 1'b1;
        #1;
        chk("t5_rst_start_ready", int'(bus.start_ready), 1);
        chk("t5_rst_in_ready",    int'(bus.in_ready), 0);
        chk("t5_rst_wr_addr",     int'(bus.wr_addr), 0);
        tick();
        bus.in_valid = 1'b0;
        reset = 1'b0;
        clear_mon();
        repeat (4) tick();
        chk("t5_no_stale_out", int'(bus.out_valid), 0);
        start_blk(1'b0);
        write_data(0, -1);
        wait_done(1, 60);
        chk("t5_wr_bank", bank_err(mon_wr_bank, 8, 0), -1);
        chk("t5_rd_seq",  seq_err(mon_rd_idx, 8, 0), -1);

        // T6 early end (full length when the feature is absent)
        do_reset();
        bus.out_ready = 1'b1;
        clear_mon();
        start_blk(1'b1);
        write_data(0, 5);
        wait_done(1, 80);
`ifdef INTLV_EARLY_END_EN
        exp_len = 5;
`else
        exp_len = 12;
`endif
        chk("t6_rd_seq", seq_err(mon_rd_idx, exp_len, 0), -1);
        chk("t6_last", (mon_last_idx.size() == 1) ? mon_last_idx[0] : -1, exp_len - 1);

        // T7 random traffic against the model, with one mid-run reset
        do_reset();
        clear_mon();
        for (int i = 0; i < 2000; i++) begin
            bus.blk_start = ($urandom_range(0, 3) == 0);
            bus.blk_sel   = 1'($urandom_range(0, 1));
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef INTLV_EARLY_END_EN
            bus.blk_end   = ($urandom_range(0, 15) == 0);
`endif
            reset = (i == 1000);
            tick();
        end
        reset = 1'b0;
        bus.blk_start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
`ifdef INTLV_EARLY_END_EN
        bus.blk_end = 1'b0;
`endif
        repeat (40) tick();
        chk("t7_progress", int'(mon_done > 10), 1);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule
